// File: rtl/eeprom_param_sequencer_pkg.sv
// Shared definitions for the I2C EEPROM controller interface and the parameter sequencer.
package eeprom_i2c_pkg;

  // Controller ctrl word bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_OP_LSB   = 1;
  localparam int CTRL_RATE_LSB = 4;
  localparam int CTRL_CLR_BIT  = 7;

  // Controller status word field positions
  localparam int STAT_FINISH_BIT = 1;
  localparam int STAT_STATE_LSB  = 2;
  localparam int STAT_STATE_W    = 8;
  localparam logic [STAT_STATE_W-1:0] STATUS_IDLE = '0;

  // I2C bit-rate codes for ctrl[6:4]
  localparam logic [2:0] RATE_390K  = 3'd7;
  localparam logic [2:0] RATE_781K  = 3'd6;
  localparam logic [2:0] RATE_1562K = 3'd5;
  localparam logic [2:0] RATE_3125K = 3'd4;

  // Width of the finish-clear pulse; long enough for the slower I2C clock domain to see an edge
  localparam int CLR_PULSE_CYCLES = 4;

  typedef enum logic [2:0] {
    CPU_WREG = 3'd0,
    CPU_RREG = 3'd1
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_CLEAR     = 3'd4,
    S_TWR       = 3'd5
  } seq_state_e;

  // EEPROM byte address of a 32-bit word; wraps within the 16-bit address space
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [31:0] idx);
    return 16'(base + 16'(idx << 2));
  endfunction

endpackage

// File: rtl/eeprom_param_sequencer_if.sv
// Sequencer <-> I2C EEPROM controller command/status bus.
interface eeprom_param_sequencer_if;
  logic [31:0] o_ctrl;
  logic [6:0]  o_dev_addr;
  logic [15:0] o_reg_addr;
  logic [31:0] o_w_data;
  logic [31:0] i_status;
  logic [7:0]  i_rd_data;
  logic [7:0]  i_rd_data_2;
  logic [7:0]  i_rd_data_3;
  logic [7:0]  i_rd_data_4;

  modport master (
    output o_ctrl, o_dev_addr, o_reg_addr, o_w_data,
    input  i_status, i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4
  );

  modport slave (
    input  o_ctrl, o_dev_addr, o_reg_addr, o_w_data,
    output i_status, i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4
  );
endinterface

// File: rtl/eeprom_param_sequencer_status_sync.sv
// Re-times a status field from the controller's I2C clock domain: 2-FF synchronizer,
// then the output only follows once two consecutive synchronized samples agree.
module status_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q, stable_q;

  // Synchronizer chain plus stability filter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      if (sync_q == prev_q) stable_q <= sync_q;
    end
  end

  assign q_o = stable_q;

endmodule

// File: rtl/eeprom_param_sequencer.sv
// Loads a block of 32-bit parameter words from an I2C EEPROM and writes single words back.
//
//  state        | meaning
//  S_IDLE       | waiting for load pulse or write request
//  S_ISSUE      | enable raised with address/op/data presented
//  S_WAIT_BUSY  | enable held until the controller leaves IDLE
//  S_WAIT_DONE  | read: wait finish; write: wait controller back in IDLE
//  S_CLEAR      | finish-clear pulse, wait finish low, next word or done
//  S_TWR        | EEPROM write cycle time / post-abort settle
module eeprom_param_sequencer
  import eeprom_i2c_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = 16,
  parameter int unsigned IDX_W          = 4,
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter logic [2:0]  CLK_RATE       = 3'd7,
  parameter int unsigned TWR_CYCLES     = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_start,
  input  logic             i_wr_req,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [31:0]      i_wr_data,
  output logic             o_wr_ack,
  output logic             o_param_we,
  output logic [IDX_W-1:0] o_param_idx,
  output logic [31:0]      o_param_data,
  output logic             o_load_done,
  output logic             o_busy,
  output logic             o_err,
  eeprom_param_sequencer_if.master bus
);

  localparam int unsigned TMR_MAX = (TWR_CYCLES > TIMEOUT_CYCLES) ? TWR_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(TMR_MAX + 1);

  seq_state_e       state_q, state_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d, pidx_q, pidx_d;
  logic [15:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d, pdata_q, pdata_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [2:0]       clr_q, clr_d;
  logic             err_q, err_d, done_q, done_d, pwe_q, pwe_d;

  logic                    fin_s;
  logic [STAT_STATE_W-1:0] cst_s;
  logic                    wr_idx_ok;
  logic                    unused_status;

  status_sync #(.WIDTH(1)) u_sync_fin (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .d_i    (bus.i_status[STAT_FINISH_BIT]),
    .q_o    (fin_s)
  );

  status_sync #(.WIDTH(STAT_STATE_W)) u_sync_state (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .d_i    (bus.i_status[STAT_STATE_LSB +: STAT_STATE_W]),
    .q_o    (cst_s)
  );

  assign unused_status = ^{bus.i_status[31:STAT_STATE_LSB+STAT_STATE_W], bus.i_status[0]};
  assign wr_idx_ok     = (32'(i_wr_idx) < NUM_WORDS);

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= CPU_WREG;
      idx_q   <= '0;
      pidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pdata_q <= '0;
      tmr_q   <= '0;
      clr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      pidx_q  <= pidx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pdata_q <= pdata_d;
      tmr_q   <= tmr_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pwe_q   <= pwe_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    pidx_d  = pidx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pdata_d = pdata_q;
    tmr_d   = tmr_q;
    clr_d   = (clr_q != '0) ? clr_q - 3'd1 : clr_q;
    err_d   = err_q;
    done_d  = done_q;
    pwe_d   = 1'b0;

    // A timeout aborts into S_TWR so the bus settles before anything new is issued
    if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE || state_q == S_CLEAR) && tmr_q == '0) begin
      err_d   = 1'b1;
      clr_d   = 3'(CLR_PULSE_CYCLES);
      tmr_d   = CNT_W'(TWR_CYCLES);
      state_d = S_TWR;
    end else begin
      if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE || state_q == S_CLEAR)
        tmr_d = tmr_q - CNT_W'(1);

      unique case (state_q)
        S_IDLE: begin
          if (i_load_start) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            idx_d   = '0;
            op_d    = CPU_RREG;
            addr_d  = word_addr(BASE_ADDR, 32'd0);
            state_d = S_ISSUE;
          end else if (i_wr_req) begin
            if (wr_idx_ok) begin
              err_d   = 1'b0;
              idx_d   = i_wr_idx;
              wdata_d = i_wr_data;
              op_d    = CPU_WREG;
              addr_d  = word_addr(BASE_ADDR, 32'(i_wr_idx));
              state_d = S_ISSUE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_ISSUE: begin
          tmr_d   = CNT_W'(TIMEOUT_CYCLES);
          state_d = S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (cst_s != STATUS_IDLE) state_d = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (op_q == CPU_RREG) begin
            if (fin_s) begin
              pwe_d   = 1'b1;
              pidx_d  = idx_q;
              pdata_d = {bus.i_rd_data, bus.i_rd_data_2, bus.i_rd_data_3, bus.i_rd_data_4};
              clr_d   = 3'(CLR_PULSE_CYCLES);
              state_d = S_CLEAR;
            end
          end else if (cst_s == STATUS_IDLE) begin
            tmr_d   = CNT_W'(TWR_CYCLES);
            state_d = S_TWR;
          end
        end
        S_CLEAR: begin
          if (clr_q == '0 && !fin_s) begin
            if (32'(idx_q) < NUM_WORDS - 1) begin
              idx_d   = idx_q + IDX_W'(1);
              addr_d  = word_addr(BASE_ADDR, 32'(idx_q) + 32'd1);
              state_d = S_ISSUE;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_TWR: begin
          if (tmr_q == '0) state_d = S_IDLE;
          else             tmr_d   = tmr_q - CNT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs; enable is level-sensitive in the controller so it only stays up until busy is seen
  always_comb begin
    bus.o_ctrl                          = '0;
    bus.o_ctrl[CTRL_EN_BIT]             = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY);
    bus.o_ctrl[CTRL_OP_LSB +: 3]        = op_q;
    bus.o_ctrl[CTRL_RATE_LSB +: 3]      = CLK_RATE;
    bus.o_ctrl[CTRL_CLR_BIT]            = (clr_q != '0);
    bus.o_dev_addr = DEV_ADDR;
    bus.o_reg_addr = addr_q;
    bus.o_w_data   = wdata_q;
    o_wr_ack       = (state_q == S_IDLE) && i_wr_req && !i_load_start;
    o_busy         = (state_q != S_IDLE);
    o_param_we     = pwe_q;
    o_param_idx    = pidx_q;
    o_param_data   = pdata_q;
    o_load_done    = done_q;
    o_err          = err_q;
  end

endmodule

// File: tb/tb_eeprom_param_sequencer.sv
// Scoreboard bench: behavioural EEPROM controller model on the bus, reference byte memory,
// expected parameter words queued at stimulus time and popped by a monitor on o_param_we.
module tb_eeprom_param_sequencer;

  localparam int unsigned NW   = 6;
  localparam int unsigned IW   = 3;
  localparam logic [6:0]  DEV  = 7'h50;
  localparam logic [15:0] BASE = 16'hFFF8;
  localparam logic [2:0]  RATE = 3'd5;
  localparam int unsigned TWR  = 40;
  localparam int unsigned TMO  = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0, wr_req = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic wr_ack, param_we, load_done, busy, err;
  logic [IW-1:0] param_idx;
  logic [31:0] param_data;

  eeprom_param_sequencer_if bus();

  eeprom_param_sequencer #(
    .NUM_WORDS(NW), .IDX_W(IW), .DEV_ADDR(DEV), .BASE_ADDR(BASE), .CLK_RATE(RATE),
    .TWR_CYCLES(TWR), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(load_start), .i_wr_req(wr_req),
    .i_wr_idx(wr_idx), .i_wr_data(wr_data), .o_wr_ack(wr_ack), .o_param_we(param_we),
    .o_param_idx(param_idx), .o_param_data(param_data), .o_load_done(load_done),
    .o_busy(busy), .o_err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [34:0] sb [$];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] bmem [0:65535];
  int pwe_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] waddr(input int k);
    return 16'(BASE + 16'(4 * k));
  endfunction

  function automatic logic [31:0] ref_word(input int k);
    logic [15:0] a = waddr(k);
    return {ref_mem[a], ref_mem[16'(a + 1)], ref_mem[16'(a + 2)], ref_mem[16'(a + 3)]};
  endfunction

  function automatic logic [31:0] bfm_word(input int k);
    logic [15:0] a = waddr(k);
    return {bmem[a], bmem[16'(a + 1)], bmem[16'(a + 2)], bmem[16'(a + 3)]};
  endfunction

  // Behavioural I2C EEPROM controller: starts on enable level, busy a random while, then
  // reads (finish=1) or writes (no finish). In nack mode it hangs busy until finish-clear.
  bit nack = 0;
  bit b_busy = 0, b_fin = 0, b_clr_prev = 0, b_read = 0, have_wr = 0;
  int b_left = 0, txn_cnt = 0, cyc = 0, last_wr_cyc = 0;
  logic [15:0] b_addr;
  logic [31:0] b_wd;

  initial begin
    bus.i_status = '0;
    bus.i_rd_data = '0; bus.i_rd_data_2 = '0; bus.i_rd_data_3 = '0; bus.i_rd_data_4 = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        b_busy = 0; b_fin = 0; b_clr_prev = 0;
      end else begin
        cyc++;
        if (bus.o_ctrl[7] && !b_clr_prev) begin
          b_fin = 0;
          if (b_busy && b_left < 0) b_busy = 0;
        end
        b_clr_prev = bus.o_ctrl[7];
        if (!b_busy) begin
          if (bus.o_ctrl[0]) begin
            txn_cnt++;
            if (have_wr) chk("twr_gap", 64'((cyc - last_wr_cyc) >= int'(TWR)), 1);
            chk("dev_addr", bus.o_dev_addr, DEV);
            chk("ctrl_rate", bus.o_ctrl[6:4], RATE);
            b_read = (bus.o_ctrl[3:1] == 3'd1);
            b_addr = bus.o_reg_addr;
            b_wd   = bus.o_w_data;
            b_left = nack ? -1 : int'($urandom_range(8, 20));
            b_busy = 1;
          end
        end else if (b_left > 0) begin
          b_left--;
          if (b_left == 0) begin
            b_busy = 0;
            chk("enable_dropped", bus.o_ctrl[0], 0);
            if (b_read) begin
              bus.i_rd_data   <= bmem[b_addr];
              bus.i_rd_data_2 <= bmem[16'(b_addr + 1)];
              bus.i_rd_data_3 <= bmem[16'(b_addr + 2)];
              bus.i_rd_data_4 <= bmem[16'(b_addr + 3)];
              b_fin = 1;
            end else begin
              bmem[b_addr]          = b_wd[31:24];
              bmem[16'(b_addr + 1)] = b_wd[23:16];
              bmem[16'(b_addr + 2)] = b_wd[15:8];
              bmem[16'(b_addr + 3)] = b_wd[7:0];
              have_wr = 1;
              last_wr_cyc = cyc;
            end
          end
        end
      end
      bus.i_status <= {22'd0, 7'd0, b_busy, b_fin, 1'b0};
    end
  end

  // Monitor: every parameter strobe must match the oldest expected word
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && param_we) begin
        pwe_cnt++;
        if (sb.size() == 0) chk("unexpected_param_we", 1, 0);
        else begin
          e = sb.pop_front();
          chk("param_idx", param_idx, e[34:32]);
          chk("param_data", param_data, e[31:0]);
        end
      end
    end
  end

  task automatic chk_reset();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_done", load_done, 0);
    chk("rst_we", param_we, 0);
    chk("rst_pidx", param_idx, 0);
    chk("rst_pdata", param_data, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_ctrl", bus.o_ctrl, {24'd0, 1'b0, RATE, 4'd0});
    chk("rst_dev", bus.o_dev_addr, DEV);
    chk("rst_addr", bus.o_reg_addr, 0);
    chk("rst_wdata", bus.o_w_data, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk("reach_idle", busy, 0);
  endtask

  task automatic push_load();
    for (int k = 0; k < int'(NW); k++) sb.push_back({IW'(k), ref_word(k)});
  endtask

  task automatic do_load(input bit ok);
    if (ok) push_load();
    @(negedge clk); load_start = 1;
    @(negedge clk); load_start = 0;
    wait_idle(8000);
    if (ok) begin
      chk("load_done", load_done, 1);
      chk("load_err", err, 0);
      chk("load_all_words", sb.size(), 0);
    end else begin
      chk("abort_err", err, 1);
      chk("abort_done", load_done, 0);
      chk("abort_ctrl_idle", b_busy, 0);
    end
  endtask

  task automatic do_write(input int idx, input logic [31:0] d);
    int n = 0, busy_cyc = 0, t0;
    bit got = 0;
    t0 = txn_cnt;
    @(negedge clk); wr_idx = IW'(idx); wr_data = d; wr_req = 1;
    while (!got && n < 3000) begin #1; got = wr_ack; @(negedge clk); n++; end
    wr_req = 0;
    chk("wr_ack_seen", got, 1);
    while (busy && busy_cyc < 5000) begin @(negedge clk); busy_cyc++; end
    if (idx < int'(NW)) begin
      chk("wr_busy_twr", 64'(busy_cyc >= int'(TWR)), 1);
      chk("wr_err", err, 0);
      chk("wr_one_txn", txn_cnt - t0, 1);
      ref_mem[waddr(idx)] = d[31:24];
      ref_mem[16'(waddr(idx) + 1)] = d[23:16];
      ref_mem[16'(waddr(idx) + 2)] = d[15:8];
      ref_mem[16'(waddr(idx) + 3)] = d[7:0];
    end else begin
      chk("badidx_busy", busy_cyc, 0);
      chk("badidx_err", err, 1);
      chk("badidx_no_txn", txn_cnt - t0, 0);
    end
  endtask

  initial begin
    int n, pw0;
    bit got;
    for (int a = 0; a < 65536; a++) begin
      ref_mem[a] = 8'(a ^ (a >> 8) ^ 32'h5A);
      bmem[a] = ref_mem[a];
    end
    repeat (4) @(negedge clk);
    chk_reset();
    rst_n = 1;
    repeat (3) @(negedge clk);

    do_load(1);
    do_write(2, 32'hDEADBEEF);
    do_load(1);
    do_write(7, 32'h12345678);
    do_write(0, 32'hCAFEF00D);
    do_load(1);

    // load and write in the same cycle: load first, write acked only after
    pw0 = pwe_cnt;
    push_load();
    @(negedge clk); load_start = 1; wr_req = 1; wr_idx = 3'd5; wr_data = 32'hA5A55A5A;
    @(negedge clk); load_start = 0;
    n = 0; got = 0;
    while (!got && n < 4000) begin #1; got = wr_ack; @(negedge clk); n++; end
    wr_req = 0;
    chk("simul_ack", got, 1);
    chk("simul_load_first", pwe_cnt - pw0, NW);
    chk("simul_done_before_ack", load_done, 1);
    wait_idle(3000);
    ref_mem[waddr(5)] = 8'hA5; ref_mem[16'(waddr(5) + 1)] = 8'hA5;
    ref_mem[16'(waddr(5) + 2)] = 8'h5A; ref_mem[16'(waddr(5) + 3)] = 8'h5A;
    do_load(1);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0) do_load(1);
      else do_write(int'($urandom_range(0, 7)), $urandom());
    end

    // device NACK: controller hangs, sequencer times out and aborts
    nack = 1;
    do_load(0);
    nack = 0;
    do_load(1);

    // reset in the middle of the second word
    pw0 = pwe_cnt;
    push_load();
    @(negedge clk); load_start = 1;
    @(negedge clk); load_start = 0;
    n = 0;
    while (pwe_cnt == pw0 && n < 2000) begin @(negedge clk); n++; end
    chk("word0_before_reset", pwe_cnt - pw0, 1);
    repeat (15) @(negedge clk);
    rst_n = 0;
    #1;
    sb.delete();
    chk_reset();
    @(negedge clk);
    chk_reset();
    rst_n = 1;
    repeat (3) @(negedge clk);
    do_load(1);

    for (int k = 0; k < int'(NW); k++) chk("eeprom_word", bfm_word(k), ref_word(k));
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
